mod_counter: RTL and testbench
==============================

# mod_counter

Parametrised modulo up/down counter, successor to the fixed 4-bit decade counter used in the display and timing paths. Adds configurable width and modulus, direction control, count enable, synchronous clear and parallel load, plus a combinational terminal-count output for cascading digits and a registered wrap pulse. It sits wherever the design needs a programmable divider or a digit stage in a multi-digit chain.

## Interface
- WIDTH, 4, bit width of the count register (1..16)
- MAX_COUNT, 9, largest count value; legal range 1..2^WIDTH-1; modulus is MAX_COUNT+1
- WRAP_MODE, 1, 1 = wrap at the limits, 0 = saturate at the limits

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous and active-high
- en  in  1  count enable; one step per clk edge while high
- dir  in  1  1 = count up, 0 = count down
- clr  in  1  synchronous clear to 0
- load  in  1  synchronous parallel load
- load_val  in  WIDTH  value to load
- count  out  WIDTH  registered count
- tc  out  1  terminal count, combinational
- wrap  out  1  registered one-cycle pulse, high the cycle after a wrap

## Operation
- Reset (rst high, asynchronous): count = 0, wrap = 0; held while rst high. tc follows its combinational equation.
- Per-edge priority: clr > load > en > hold.
  - clr: count <= 0, wrap <= 0.
  - load: count <= min(load_val, MAX_COUNT); wrap <= 0. Over-range load values clamp to MAX_COUNT.
  - en, dir=1: count < MAX_COUNT -> count+1; count == MAX_COUNT -> 0 if WRAP_MODE=1 (wrap <= 1), hold at MAX_COUNT if WRAP_MODE=0.
  - en, dir=0: count > 0 -> count-1; count == 0 -> MAX_COUNT if WRAP_MODE=1 (wrap <= 1), hold at 0 if WRAP_MODE=0.
  - Otherwise: count holds, wrap <= 0.
- wrap is high only for the single cycle following a wrapping step. It never asserts when WRAP_MODE=0.
- tc = en & ((dir & count == MAX_COUNT) | (~dir & count == 0)). It is independent of clr and load and is asserted in both modes. Cascading: the next stage's en is driven by this stage's tc.
- Arithmetic is modulo-free: comparisons are against MAX_COUNT and 0, never 2^WIDTH. count is never observed above MAX_COUNT.
- A dir change takes effect on the next enabled edge. No dead cycle.

## Timing
- count latency: 1 clk from en/clr/load/dir sampled to new value.
- wrap: asserted the same edge count wraps, deasserted the next edge unless another wrap occurs. With MAX_COUNT=1 and continuous up-count, wrap is high every other cycle.
- tc: same-cycle combinational from count, en, dir. No register stage.
- rst asserted mid-count: count and wrap go to 0 immediately, without waiting for clk. On deassertion, counting resumes on the first clk edge where en=1.
- clr and load are both ignored while rst is high.

## Test plan
- Reset/up-wrap (defaults): assert rst mid-count -> count=0, wrap=0 asynchronously. Release, en=1, dir=1 for 12 edges -> count 1..9,0,1,2; wrap high only in the cycle count=0; tc high while count=9.
- Down-wrap: load_val=2 with load, then en=1, dir=0 -> count 2,1,0,9,8; tc high at count=0; wrap high at count=9.
- Saturate (WRAP_MODE=0, WIDTH=8, MAX_COUNT=200): load 198, up-count 5 edges -> 199,200,200,200,200; wrap stays 0; tc stays 1 at 200.
- Priority: clr=1, load=1, load_val=5, en=1 same edge -> count=0. Then load=1, en=1, load_val=12 -> count=9 (clamped). Then en=0 for 3 edges -> count holds 9, tc=0.
- Cascade: two instances with defaults; stage B en = stage A tc; run 100 edges from reset -> B:A reads 0:0 after 100 edges, every intermediate value equals edge count mod 100, and B wrap pulses once.

Source files
------------

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//
// Parametrised modulo up/down counter. One stage of a programmable divider or
// one digit of a multi-digit chain. Counts 0..MAX_COUNT, either wrapping at the
// limits (WRAP_MODE=1) or saturating there (WRAP_MODE=0).
//
// Parameters:
//   WIDTH      bit width of the count register (1..16)
//   MAX_COUNT  largest count value (1..2^WIDTH-1); modulus is MAX_COUNT+1
//   WRAP_MODE  1 = wrap at the limits, 0 = saturate at the limits
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   en        in   count enable, one step per edge while high
//   dir       in   1 = up, 0 = down
//   clr       in   synchronous clear (highest priority)
//   load      in   synchronous parallel load (clamped to MAX_COUNT)
//   load_val  in   value to load
//   count     out  registered count
//   tc        out  combinational terminal count (drives next stage's en)
//   wrap      out  registered one-cycle pulse after a wrapping step
// -----------------------------------------------------------------------------
module mod_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 9,
    parameter int WRAP_MODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ZERO_V = '0;
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
    localparam bit               WRAP_EN = (WRAP_MODE != 0);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             at_max;
    logic             at_zero;

    // Limits are MAX_COUNT and 0, never 2^WIDTH, so the register never
    // holds a value above MAX_COUNT.
    assign at_max  = (count_q == MAX_V);
    assign at_zero = (count_q == ZERO_V);

    // Next-state: clr > load > en > hold. wrap_d defaults low so the pulse
    // lasts exactly one cycle unless another wrap follows immediately.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = ZERO_V;
        end else if (load) begin
            // Over-range load values clamp rather than alias.
            count_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            if (dir) begin
                if (!at_max) begin
                    count_d = count_q + ONE_V;
                end else if (WRAP_EN) begin
                    count_d = ZERO_V;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_d = count_q - ONE_V;
                end else if (WRAP_EN) begin
                    count_d = MAX_V;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= ZERO_V;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // Terminal count is purely combinational so a cascaded stage steps on the
    // same edge this stage wraps. It ignores clr/load and is active in both
    // wrap and saturate modes.
    assign tc    = en & ((dir & at_max) | (~dir & at_zero));
    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_mod_counter.sv
module tb_mod_counter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Default instance: WIDTH=4, MAX_COUNT=9, wrapping
    logic       a_en, a_dir, a_clr, a_load;
    logic [3:0] a_lv, a_count;
    logic       a_tc, a_wrap;

    // Saturating instance: WIDTH=8, MAX_COUNT=200
    logic       s_en, s_dir, s_clr, s_load;
    logic [7:0] s_lv, s_count;
    logic       s_tc, s_wrap;

    // Two-digit cascade
    logic       c_en;
    logic [3:0] ca_count, cb_count;
    logic       ca_tc, cb_tc, ca_wrap, cb_wrap;

    mod_counter u_a (
        .clk(clk), .rst(rst), .en(a_en), .dir(a_dir), .clr(a_clr), .load(a_load),
        .load_val(a_lv), .count(a_count), .tc(a_tc), .wrap(a_wrap)
    );

    mod_counter #(.WIDTH(8), .MAX_COUNT(200), .WRAP_MODE(0)) u_s (
        .clk(clk), .rst(rst), .en(s_en), .dir(s_dir), .clr(s_clr), .load(s_load),
        .load_val(s_lv), .count(s_count), .tc(s_tc), .wrap(s_wrap)
    );

    mod_counter u_ca (
        .clk(clk), .rst(rst), .en(c_en), .dir(1'b1), .clr(1'b0), .load(1'b0),
        .load_val(4'd0), .count(ca_count), .tc(ca_tc), .wrap(ca_wrap)
    );

    mod_counter u_cb (
        .clk(clk), .rst(rst), .en(ca_tc), .dir(1'b1), .clr(1'b0), .load(1'b0),
        .load_val(4'd0), .count(cb_count), .tc(cb_tc), .wrap(cb_wrap)
    );

    typedef struct {
        int which;
        int cnt;
        int wrp;
    } exp_t;
    exp_t sb[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One transaction: drive inputs, check tc before the edge, push the
    // expected post-edge count/wrap, clock, then pop and compare.
    task automatic step(input int which, input logic en, input logic dir,
                        input logic clr, input logic load, input int lv,
                        input int exp_tc, input int exp_cnt, input int exp_wrap);
        exp_t e;
        exp_t p;
        if (which == 0) begin
            a_en = en; a_dir = dir; a_clr = clr; a_load = load; a_lv = 4'(lv);
        end else begin
            s_en = en; s_dir = dir; s_clr = clr; s_load = load; s_lv = 8'(lv);
        end
        #1;
        check_val(which == 0 ? "a_tc" : "s_tc", 32'(which == 0 ? a_tc : s_tc), 32'(exp_tc));
        e.which = which; e.cnt = exp_cnt; e.wrp = exp_wrap;
        sb.push_back(e);
        @(posedge clk);
        #1;
        p = sb.pop_front();
        if (p.which == 0) begin
            check_val("a_count", 32'(a_count), 32'(p.cnt));
            check_val("a_wrap", 32'(a_wrap), 32'(p.wrp));
            $display("step a en=%0b dir=%0b clr=%0b load=%0b lv=%0d -> count=%0d wrap=%0b",
                     en, dir, clr, load, lv, a_count, a_wrap);
        end else begin
            check_val("s_count", 32'(s_count), 32'(p.cnt));
            check_val("s_wrap", 32'(s_wrap), 32'(p.wrp));
            $display("step s en=%0b dir=%0b clr=%0b load=%0b lv=%0d -> count=%0d wrap=%0b",
                     en, dir, clr, load, lv, s_count, s_wrap);
        end
    endtask

    int up_exp[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int sat_exp[5] = '{199, 200, 200, 200, 200};

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int b_wraps;
        int cur;
        rst = 1'b1;
        a_en = 0; a_dir = 1; a_clr = 0; a_load = 0; a_lv = '0;
        s_en = 0; s_dir = 1; s_clr = 0; s_load = 0; s_lv = '0;
        c_en = 0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_a_count", 32'(a_count), 0);
        check_val("rst_a_wrap", 32'(a_wrap), 0);
        check_val("rst_a_tc", 32'(a_tc), 0);
        check_val("rst_s_count", 32'(s_count), 0);
        rst = 1'b0;

        // Cascade: 100 edges, B:A must track edge count mod 100
        c_en = 1'b1;
        b_wraps = 0;
        for (int e = 1; e <= 100; e++) begin
            exp_t x;
            exp_t p;
            check_val("casc_a_tc", 32'(ca_tc), 32'(((e - 1) % 10) == 9));
            x.which = 2; x.cnt = e % 100; x.wrp = 0;
            sb.push_back(x);
            @(posedge clk);
            #1;
            p = sb.pop_front();
            check_val("casc_value", 32'(int'(cb_count) * 10 + int'(ca_count)), 32'(p.cnt));
            if (cb_wrap) b_wraps++;
            $display("casc edge=%0d B:A=%0d:%0d b_wrap=%0b", e, cb_count, ca_count, cb_wrap);
        end
        c_en = 1'b0;
        #1;
        check_val("casc_b_wraps", 32'(b_wraps), 1);
        check_val("casc_b_tc", 32'(cb_tc), 0);

        // Up-wrap on default instance: 1..9,0,1,2; tc while count=9
        cur = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 1, 0, 0, 0, (cur == 9) ? 1 : 0, up_exp[i], (up_exp[i] == 0 && i == 9) ? 1 : 0);
            cur = up_exp[i];
        end
        // Run on to 9, then wrap to 0 so the wrap pulse is high
        for (int v = 3; v <= 9; v++) step(0, 1, 1, 0, 0, 0, 0, v, 0);
        step(0, 1, 1, 0, 0, 0, 1, 0, 1);

        // Asynchronous reset mid-cycle while wrap is high
        a_en = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_count", 32'(a_count), 0);
        check_val("async_rst_wrap", 32'(a_wrap), 0);
        @(posedge clk);
        #1;
        check_val("rst_hold_count", 32'(a_count), 0);
        rst = 1'b0;
        a_en = 1'b0;

        // Down-wrap: load 2, then 1,0,9,8
        step(0, 0, 0, 0, 1, 2, 0, 2, 0);
        step(0, 1, 0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 1, 9, 1);
        step(0, 1, 0, 0, 0, 0, 0, 8, 0);

        // Priority: clr beats load and en
        step(0, 1, 1, 1, 1, 5, 0, 0, 0);
        // load beats en, over-range value clamps to 9
        step(0, 1, 1, 0, 1, 12, 0, 9, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0, 9, 0);
        // tc ignores load: en=1,dir=1 at 9 shows tc while the load proceeds
        step(0, 1, 1, 0, 1, 3, 1, 3, 0);

        // Saturate instance
        step(1, 0, 1, 0, 1, 198, 0, 198, 0);
        cur = 198;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 1, 0, 0, 0, (cur == 200) ? 1 : 0, sat_exp[i], 0);
            cur = sat_exp[i];
        end
        step(1, 0, 1, 0, 1, 255, 0, 200, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
